// File: rtl/hms_pkg.sv
// Shared types, load addresses and field limits for the HMS timekeeper with alarm.
// Wrap helpers keep the increment/decrement rules identical for every field.
package hms_pkg;

    typedef enum logic [2:0] {
        RUN = 3'd0,
        PL  = 3'd1,
        HB  = 3'd2,
        MB  = 3'd3,
        SB  = 3'd4
    } state_t;

    localparam logic [2:0] A_SEC  = 3'd1;
    localparam logic [2:0] A_MIN  = 3'd2;
    localparam logic [2:0] A_HRS  = 3'd3;
    localparam logic [2:0] A_ASEC = 3'd4;
    localparam logic [2:0] A_AMIN = 3'd5;
    localparam logic [2:0] A_AHRS = 3'd6;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [4:0] HRS_MAX = 5'd23;

    function automatic logic [5:0] inc6(input logic [5:0] v);
        return (v >= SEC_MAX) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] dec6(input logic [5:0] v);
        return (v == 6'd0) ? SEC_MAX : v - 6'd1;
    endfunction

    function automatic logic [4:0] inc5(input logic [4:0] v);
        return (v >= HRS_MAX) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [4:0] dec5(input logic [4:0] v);
        return (v == 5'd0) ? HRS_MAX : v - 5'd1;
    endfunction

endpackage

// File: rtl/hms_tick_div.sv
// Cycle prescaler: one-cycle tick every TICK_DIV enabled cycles.
// Disabling holds the count at zero so the next period starts fresh.
module hms_tick_div #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hms_rtc_alarm.sv
// Hours/minutes/seconds clock with edit mode, range-checked loads and a timed alarm.
// Time advances on the prescaler tick only while in RUN.
module hms_rtc_alarm
    import hms_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int TIMEOUT   = 30,
    parameter int ALARM_LEN = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] din,
    input  logic [2:0] addr,
    input  logic       load,
    input  logic       ss,
    input  logic       sel,
    input  logic       inc,
    input  logic       dec,
    input  logic       alm_en,
    input  logic       alm_ack,
    output logic [4:0] hrs,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       alarm_on,
    output logic       edit
);

    localparam int IW  = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);
    localparam int ACW = (ALARM_LEN > 1) ? $clog2(ALARM_LEN) : 1;
    localparam logic [ACW-1:0] ALM_LAST = ACW'(ALARM_LEN - 1);

    state_t           r_state;
    logic             r_edit;
    logic [IW-1:0]    r_idle;
    logic [4:0]       r_hrs, r_ah;
    logic [5:0]       r_min, r_sec, r_am, r_as;
    logic             r_alarm;
    logic [ACW-1:0]   r_acnt;

    logic       w_tick;
    logic       w_activity;
    logic       w_timeout;
    logic       w_sec_wrap, w_min_wrap;
    logic [5:0] w_sec_t, w_min_t;
    logic [4:0] w_hrs_t;
    logic       w_trigger;

    hms_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_state == RUN),
        .o_tick (w_tick)
    );

    assign w_activity = ss | sel | inc | dec | load;
    assign w_timeout  = (r_state != RUN) && (r_idle == IDLE_MAX) && !w_activity;

    // Time as it will read after this tick; the alarm compares against it.
    assign w_sec_wrap = (r_sec == SEC_MAX);
    assign w_min_wrap = (r_min == SEC_MAX);
    assign w_sec_t    = inc6(r_sec);
    assign w_min_t    = w_sec_wrap ? inc6(r_min) : r_min;
    assign w_hrs_t    = (w_sec_wrap && w_min_wrap) ? inc5(r_hrs) : r_hrs;
    assign w_trigger  = (r_state == RUN) && w_tick && alm_en &&
                        (w_hrs_t == r_ah) && (w_min_t == r_am) && (w_sec_t == r_as);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_edit  <= 1'b0;
            r_idle  <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    r_idle <= '0;
                    if (ss) begin
                        r_state <= PL;
                        r_edit  <= 1'b1;
                    end
                end
                default: begin
                    if (sel) begin
                        case (r_state)
                            PL:      r_state <= HB;
                            HB:      r_state <= MB;
                            MB:      r_state <= SB;
                            default: r_state <= HB;
                        endcase
                    end else if (ss || w_timeout) begin
                        r_state <= RUN;
                        r_edit  <= 1'b0;
                    end
                    if (w_activity) begin
                        r_idle <= '0;
                    end else if (r_idle != IDLE_MAX) begin
                        r_idle <= r_idle + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hrs <= '0;
            r_min <= '0;
            r_sec <= '0;
            r_ah  <= '0;
            r_am  <= '0;
            r_as  <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_tick) begin
                        r_hrs <= w_hrs_t;
                        r_min <= w_min_t;
                        r_sec <= w_sec_t;
                    end
                end
                PL: begin
                    if (load) begin
                        case (addr)
                            A_SEC:   if (din <= SEC_MAX)       r_sec <= din;
                            A_MIN:   if (din <= SEC_MAX)       r_min <= din;
                            A_HRS:   if (din <= 6'(HRS_MAX))   r_hrs <= din[4:0];
                            A_ASEC:  if (din <= SEC_MAX)       r_as  <= din;
                            A_AMIN:  if (din <= SEC_MAX)       r_am  <= din;
                            A_AHRS:  if (din <= 6'(HRS_MAX))   r_ah  <= din[4:0];
                            default: ;
                        endcase
                    end
                end
                HB: begin
                    if (inc)      r_hrs <= inc5(r_hrs);
                    else if (dec) r_hrs <= dec5(r_hrs);
                end
                MB: begin
                    if (inc)      r_min <= inc6(r_min);
                    else if (dec) r_min <= dec6(r_min);
                end
                SB: begin
                    if (inc)      r_sec <= inc6(r_sec);
                    else if (dec) r_sec <= dec6(r_sec);
                end
                default: ;
            endcase
        end
    end

    // Clearing beats a same-cycle trigger; outside RUN no ticks arrive, so the counter freezes.
    always_ff @(posedge clk) begin
        if (rst || alm_ack || !alm_en) begin
            r_alarm <= 1'b0;
            r_acnt  <= '0;
        end else if (w_trigger) begin
            r_alarm <= 1'b1;
            r_acnt  <= '0;
        end else if (r_alarm && (r_state == RUN) && w_tick) begin
            if (r_acnt == ALM_LAST) begin
                r_alarm <= 1'b0;
                r_acnt  <= '0;
            end else begin
                r_acnt <= r_acnt + 1'b1;
            end
        end
    end

    assign hrs      = r_hrs;
    assign min      = r_min;
    assign sec      = r_sec;
    assign alarm_on = r_alarm;
    assign edit     = r_edit;

endmodule

// File: tb/tb_hms_rtc_alarm.sv
// Directed bench: dut_a (TICK_DIV=4) covers rollover, timeout, loads and edits;
// dut_b (TICK_DIV=1, ALARM_LEN=3) covers alarm timing, acknowledge and reset.
module tb_hms_rtc_alarm;

    logic       clk = 1'b0;
    logic       rst, load, ss, sel, inc, dec, alm_en, alm_ack;
    logic [5:0] din;
    logic [2:0] addr;

    logic [4:0] a_hrs, b_hrs;
    logic [5:0] a_min, a_sec, b_min, b_sec;
    logic       a_alarm, a_edit, b_alarm, b_edit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hms_rtc_alarm #(.TICK_DIV(4), .TIMEOUT(30), .ALARM_LEN(3)) dut_a (
        .clk(clk), .rst(rst), .din(din), .addr(addr), .load(load), .ss(ss),
        .sel(sel), .inc(inc), .dec(dec), .alm_en(alm_en), .alm_ack(alm_ack),
        .hrs(a_hrs), .min(a_min), .sec(a_sec), .alarm_on(a_alarm), .edit(a_edit)
    );

    hms_rtc_alarm #(.TICK_DIV(1), .TIMEOUT(30), .ALARM_LEN(3)) dut_b (
        .clk(clk), .rst(rst), .din(din), .addr(addr), .load(load), .ss(ss),
        .sel(sel), .inc(inc), .dec(dec), .alm_en(alm_en), .alm_ack(alm_ack),
        .hrs(b_hrs), .min(b_min), .sec(b_sec), .alarm_on(b_alarm), .edit(b_edit)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("check %s observed=%0d expected=%0d", tag, obs, exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ss();
        ss = 1'b1; cyc(1); ss = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] a, input logic [5:0] d);
        load = 1'b1; addr = a; din = d; cyc(1); load = 1'b0; addr = 3'd0; din = 6'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load = 0; ss = 0; sel = 0; inc = 0; dec = 0;
        alm_en = 0; alm_ack = 0; din = 0; addr = 0;
        cyc(1);
        rst = 1'b0;
        chk("rst_hrs", a_hrs, 0);
        chk("rst_min", a_min, 0);
        chk("rst_sec", a_sec, 0);
        chk("rst_alarm", a_alarm, 0);
        chk("rst_edit", a_edit, 0);

        // Loads with range checking, then rollover at TICK_DIV=4
        pulse_ss();
        chk("pl_edit", a_edit, 1);
        do_load(3'd3, 6'd23);
        do_load(3'd2, 6'd59);
        do_load(3'd1, 6'd58);
        do_load(3'd1, 6'd60);
        chk("load_sec60_ignored", a_sec, 58);
        do_load(3'd3, 6'd24);
        chk("load_hrs24_ignored", a_hrs, 23);
        do_load(3'd0, 6'd5);
        do_load(3'd7, 6'd5);
        chk("noop_hrs", a_hrs, 23);
        chk("noop_min", a_min, 59);
        chk("noop_sec", a_sec, 58);
        do_load(3'd1, 6'd45);
        chk("load_sec45", a_sec, 45);
        do_load(3'd1, 6'd58);
        pulse_ss();
        chk("run_edit", a_edit, 0);
        cyc(3);
        chk("sec_before_tick", a_sec, 58);
        cyc(1);
        chk("sec_59", a_sec, 59);
        cyc(4);
        chk("wrap_hrs", a_hrs, 0);
        chk("wrap_min", a_min, 0);
        chk("wrap_sec", a_sec, 0);

        // Idle timeout, then timeout delayed by an inc at idle count 20
        pulse_ss();
        chk("to_enter", a_edit, 1);
        cyc(30);
        chk("to_cycle30", a_edit, 1);
        cyc(1);
        chk("to_cycle31", a_edit, 0);
        pulse_ss();
        cyc(20);
        inc = 1'b1; cyc(1); inc = 1'b0;
        cyc(10);
        chk("to_delayed_a", a_edit, 1);
        cyc(20);
        chk("to_delayed_b", a_edit, 1);
        cyc(1);
        chk("to_delayed_end", a_edit, 0);

        // Field edits in HB/MB/SB
        rst = 1'b1; cyc(1); rst = 1'b0;
        pulse_ss();
        sel = 1'b1; cyc(1); sel = 1'b0;
        dec = 1'b1; cyc(1); dec = 1'b0;
        chk("hb_dec_wrap", a_hrs, 23);
        sel = 1'b1; cyc(1); sel = 1'b0;
        dec = 1'b1; cyc(1); dec = 1'b0;
        chk("mb_dec_wrap", a_min, 59);
        inc = 1'b1; dec = 1'b1; cyc(1); inc = 1'b0; dec = 1'b0;
        chk("mb_inc_wins", a_min, 0);
        sel = 1'b1; inc = 1'b1; cyc(1); sel = 1'b0; inc = 1'b0;
        chk("sel_inc_old_field", a_min, 1);
        chk("sel_inc_sec_hold", a_sec, 0);
        inc = 1'b1; cyc(1); inc = 1'b0;
        chk("sb_inc", a_sec, 1);
        chk("sb_min_hold", a_min, 1);
        sel = 1'b1; cyc(1); sel = 1'b0;
        inc = 1'b1; cyc(1); inc = 1'b0;
        chk("sb_to_hb_inc_wrap", a_hrs, 0);
        chk("edit_still", a_edit, 1);
        pulse_ss();
        chk("edit_exit", a_edit, 0);

        // Alarm at 00:00:05 on dut_b
        rst = 1'b1; cyc(1); rst = 1'b0;
        pulse_ss();
        do_load(3'd1, 6'd0);
        do_load(3'd4, 6'd5);
        do_load(3'd5, 6'd0);
        do_load(3'd6, 6'd0);
        alm_en = 1'b1;
        pulse_ss();
        chk("alm_start_sec", b_sec, 0);
        chk("alm_start_off", b_alarm, 0);
        cyc(4);
        chk("alm_sec4_sec", b_sec, 4);
        chk("alm_sec4_off", b_alarm, 0);
        cyc(1);
        chk("alm_sec5_sec", b_sec, 5);
        chk("alm_sec5_on", b_alarm, 1);
        cyc(2);
        chk("alm_sec7_on", b_alarm, 1);
        cyc(1);
        chk("alm_sec8_sec", b_sec, 8);
        chk("alm_sec8_off", b_alarm, 0);

        // Acknowledge at sec=6
        pulse_ss();
        do_load(3'd1, 6'd0);
        pulse_ss();
        cyc(5);
        chk("ack_sec5_on", b_alarm, 1);
        cyc(1);
        chk("ack_sec6_sec", b_sec, 6);
        chk("ack_sec6_on", b_alarm, 1);
        alm_ack = 1'b1; cyc(1); alm_ack = 1'b0;
        chk("ack_cleared", b_alarm, 0);
        chk("ack_sec7", b_sec, 7);
        cyc(2);
        chk("ack_stays_off", b_alarm, 0);

        // Reset while the alarm is active
        pulse_ss();
        do_load(3'd1, 6'd0);
        pulse_ss();
        cyc(6);
        chk("mid_alarm_on", b_alarm, 1);
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("mid_rst_hrs", b_hrs, 0);
        chk("mid_rst_min", b_min, 0);
        chk("mid_rst_sec", b_sec, 0);
        chk("mid_rst_alarm", b_alarm, 0);
        chk("mid_rst_edit", b_edit, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
